pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipelined RISC-V core (IF/ID/EX/MEM/WB) built from the existing single-cycle datapath blocks.
- Keeps a shadow pipeline of per-stage register-use metadata.
- From that metadata it generates:
  - PC and IF/ID write enables;
  - IF/ID and ID/EX flushes;
  - the global freeze while data memory is busy;
  - ALU operand forwarding selects.
- Also counts stall and flush cycles for bubble-sort performance measurement.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: asserted when 0.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1  in  REG_AW  ID-stage source register 1.
- id_rs2  in  REG_AW  ID-stage source register 2.
- id_rd  in  REG_AW  ID-stage destination register.
- id_regwrite  in  1  ID-stage instruction writes the register file.
- id_memread  in  1  ID-stage instruction is a load.
- id_memwrite  in  1  ID-stage instruction is a store.
- ex_branch_taken  in  1  branch in EX is resolved as taken this cycle.
- dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to a NOP.
- idex_flush  out  1  load a bubble into ID/EX.
- pipe_freeze  out  1  hold every pipeline register.
- fwd_a  out  2  EX operand A select: 00 register file, 01 WB result, 10 MEM result.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cycles  out  CNT_W  count of load-use stall cycles.
- flush_cycles  out  CNT_W  count of branch flush cycles.

Behaviour:
- Shadow registers per stage:
  - EX: valid, rs1, rs2, rd, regwrite, memread, memaccess.
  - MEM: valid, rd, regwrite, memaccess.
  - WB: valid, rd, regwrite.
- Reset (reset=0, asynchronous): all shadow valid bits and both counters clear to 0. Outputs then read: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, pipe_freeze=0, fwd_a=00, fwd_b=00.
- Control outputs are combinational from the current shadow state and ID inputs (zero latency). Shadow state updates at the clock edge.
- Condition priority, highest first:
  1. FREEZE: mem_valid & mem_memaccess & !dmem_ready.
     - pipe_freeze=1, pc_write=0, ifid_write=0, no flushes.
     - All shadow registers and counters hold.
  2. FLUSH: ex_branch_taken.
     - ifid_flush=1, idex_flush=1, pc_write=1.
     - EX shadow gets a bubble (valid=0); flush_cycles increments.
  3. LOAD-USE: id_valid & ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
     - pc_write=0, ifid_write=0, idex_flush=1.
     - EX shadow gets a bubble; stall_cycles increments.
  4. NORMAL: EX shadow loads the ID inputs, with valid=id_valid and memaccess=id_memread|id_memwrite.
- Shadow advance: in every non-freeze cycle, MEM takes EX and WB takes MEM.
- Branch during freeze: the branch stays in EX, so ex_branch_taken is still asserted when the freeze releases. The flush is applied on that first unfrozen cycle, exactly once.
- Load-use during freeze: re-evaluated after the freeze releases; the stall is not counted during frozen cycles.
- Forwarding, fwd_a (fwd_b identical using ex_rs2):
  - 10 if mem_valid & mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1;
  - else 01 if wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1;
  - else 00.
  - MEM has priority over WB (youngest value wins).
  - x0 is never forwarded.
  - Forward selects are driven during freeze too; they are unused because nothing advances.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall or mid-freeze: all bubbles are dropped immediately and the next cycle behaves as an empty pipeline.

Decomposition:
- Shared package riscv_pipe_pkg:
  - REG_AW default;
  - forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - packed stage-metadata struct (valid, rd, rs1, rs2, regwrite, memread, memaccess).
- One natural sub-module: forward_sel, a purely combinational comparator instantiated twice (operand A and operand B).
- The priority logic, shadow pipeline and counters stay in pipeline_hazard_ctrl.

Test Plan:
- Reset, then no ID instructions → pc_write=1, ifid_write=1, fwd_a=fwd_b=00, both counters 0.
- "ld x5" issued, next cycle ID holds "add x6,x5,x7" → one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1. The following cycle has fwd_a=01 (x5 forwarded from WB).
- "add x5,x1,x2" then "sub x6,x5,x5" → fwd_a=fwd_b=10 with no stall. Repeat with an unrelated instruction between the two → fwd_a=fwd_b=01.
- Writes to x0 in MEM and WB while EX reads x0 → fwd_a=00 and no load-use stall.
- ex_branch_taken=1 for one cycle → ifid_flush=idex_flush=1 in that cycle; flush_cycles=1; the next cycle's EX metadata is invalid (no forwarding from it).
- Store reaches MEM with dmem_ready=0 for 3 cycles while ex_branch_taken=1 → pipe_freeze=1 for 3 cycles with no flush. Flush occurs in cycle 4; flush_cycles increments by exactly 1.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the 5-stage pipeline control: forwarding encodings,
// hazard condition names and the per-stage shadow metadata records.
package riscv_pipe_pkg;

  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    COND_NORMAL,
    COND_LOAD_USE,
    COND_FLUSH,
    COND_FREEZE
  } hazard_cond_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_AW_DEFAULT-1:0] rd;
    logic [REG_AW_DEFAULT-1:0] rs1;
    logic [REG_AW_DEFAULT-1:0] rs2;
    logic                      regwrite;
    logic                      memread;
    logic                      memaccess;
  } stage_meta_t;

  // Later stages only need the fields their hazards actually consult.
  typedef struct packed {
    logic                      valid;
    logic [REG_AW_DEFAULT-1:0] rd;
    logic                      regwrite;
    logic                      memaccess;
  } mem_meta_t;

  typedef struct packed {
    logic                      valid;
    logic [REG_AW_DEFAULT-1:0] rd;
    logic                      regwrite;
  } wb_meta_t;

endpackage

// File: rtl/forward_sel.sv
// Combinational forwarding select for one EX operand; the youngest
// in-flight producer (MEM) wins over WB, and x0 is never forwarded.
module forward_sel
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              mem_valid_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_valid_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [REG_AW-1:0] ex_rs_i,
  output fwd_sel_e          sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_valid_i & mem_regwrite_i & (mem_rd_i != '0) & (mem_rd_i == ex_rs_i);
  assign wb_hit  = wb_valid_i  & wb_regwrite_i  & (wb_rd_i  != '0) & (wb_rd_i  == ex_rs_i);

  // NOTE: assigning a default before any branch keeps combinational logic latch-free.
  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit) begin
      sel_o = FWD_MEM;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: shadow register-use
// pipeline, freeze/flush/load-use priority, forwarding selects and perf counters.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              ex_branch_taken,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
);

  stage_meta_t      ex_q, ex_d;
  mem_meta_t        mem_q, mem_d;
  wb_meta_t         wb_q, wb_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

  hazard_cond_e cond;
  logic         load_use;
  stage_meta_t  id_meta;
  fwd_sel_e     fwd_a_sel;
  fwd_sel_e     fwd_b_sel;

  assign load_use = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0)
                  & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  always_comb begin
    id_meta           = '0;
    id_meta.valid     = id_valid;
    id_meta.rd        = id_rd;
    id_meta.rs1       = id_rs1;
    id_meta.rs2       = id_rs2;
    id_meta.regwrite  = id_regwrite;
    id_meta.memread   = id_memread;
    id_meta.memaccess = id_memread | id_memwrite;
  end

  // A pending branch stays in EX while frozen, so it is honoured exactly once on release.
  always_comb begin
    cond = COND_NORMAL;
    if (mem_q.valid & mem_q.memaccess & ~dmem_ready) begin
      cond = COND_FREEZE;
    end else if (ex_branch_taken) begin
      cond = COND_FLUSH;
    end else if (load_use) begin
      cond = COND_LOAD_USE;
    end
  end

  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    pipe_freeze    = 1'b0;
    ex_d           = id_meta;
    mem_d          = '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite,
                       memaccess: ex_q.memaccess};
    wb_d           = '{valid: mem_q.valid, rd: mem_q.rd, regwrite: mem_q.regwrite};
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    unique case (cond)
      COND_FREEZE: begin
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
      end
      COND_FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        ex_d       = '0;
        if (flush_cycles_q != '1) flush_cycles_d = flush_cycles_q + CNT_W'(1);
      end
      COND_LOAD_USE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        ex_d       = '0;
        if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: shadow metadata is a handful of flops, not a memory, so clearing it all on reset is cheap and keeps x out of the comparators.
      ex_q           <= '0;
      mem_q          <= '0;
      wb_q           <= '0;
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      wb_q           <= wb_d;
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  forward_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .ex_rs_i        (ex_q.rs1),
    .sel_o          (fwd_a_sel)
  );

  forward_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .ex_rs_i        (ex_q.rs2),
    .sel_o          (fwd_b_sel)
  );

  assign fwd_a        = fwd_a_sel;
  assign fwd_b        = fwd_b_sel;
  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors push
// hand-computed expectations; a monitor pops and compares at each falling edge.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       mw;
  } instr_t;

  // ctrl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}
  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  localparam logic [4:0] NRM = 5'b11000;
  localparam logic [4:0] LU  = 5'b00010;
  localparam logic [4:0] FL  = 5'b11110;
  localparam logic [4:0] FZ  = 5'b00001;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_regwrite, id_memread, id_memwrite;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_branch_taken, dmem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles, flush_cycles;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pipe_freeze     (pipe_freeze),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
  );

  function automatic instr_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic rw, logic mr, logic mw);
    instr_t i;
    i = '{v: v, rs1: rs1, rs2: rs2, rd: rd, rw: rw, mr: mr, mw: mw};
    return i;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue what the DUT must show.
  task automatic step(input string nm, input instr_t ins, input logic br, input logic rdy,
                      input logic rst, input logic [4:0] ctrl, input logic [1:0] fa,
                      input logic [1:0] fb, input int s, input int f);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    id_valid        = ins.v;
    id_rs1          = ins.rs1;
    id_rs2          = ins.rs2;
    id_rd           = ins.rd;
    id_regwrite     = ins.rw;
    id_memread      = ins.mr;
    id_memwrite     = ins.mw;
    ex_branch_taken = br;
    dmem_ready      = rdy;
    e = '{name: nm, ctrl: ctrl, fa: fa, fb: fb, stall: 32'(s), flush: 32'(f)};
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({e.name, ".ctrl"}, {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze},
              {27'd0, e.ctrl});
        check({e.name, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e.fa});
        check({e.name, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e.fb});
        check({e.name, ".stall"}, stall_cycles, e.stall);
        check({e.name, ".flush"}, flush_cycles, e.flush);
      end
    end
  end

  initial begin : stimulus
    instr_t idle;
    idle            = '0;
    reset           = 1'b0;
    id_valid        = 1'b0;
    id_rs1          = '0;
    id_rs2          = '0;
    id_rd           = '0;
    id_regwrite     = 1'b0;
    id_memread      = 1'b0;
    id_memwrite     = 1'b0;
    ex_branch_taken = 1'b0;
    dmem_ready      = 1'b1;

    step("reset",  idle, 0, 1, 0, NRM, 0, 0, 0, 0);
    step("idle0",  idle, 0, 1, 1, NRM, 0, 0, 0, 0);
    step("idle1",  idle, 0, 1, 1, NRM, 0, 0, 0, 0);

    // load-use: ld x5 then add x6,x5,x7
    step("lu_ld",    mk(1, 1, 0, 5, 1, 1, 0), 0, 1, 1, NRM, 0, 0, 0, 0);
    step("lu_stall", mk(1, 5, 7, 6, 1, 0, 0), 0, 1, 1, LU,  0, 0, 0, 0);
    step("lu_retry", mk(1, 5, 7, 6, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("lu_fwdwb", idle,                    0, 1, 1, NRM, 1, 0, 1, 0);
    repeat (3) step("lu_drain", idle, 0, 1, 1, NRM, 0, 0, 1, 0);

    // back-to-back ALU dependency: forward from MEM
    step("mem_add", mk(1, 1, 2, 5, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("mem_sub", mk(1, 5, 5, 6, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("mem_fwd", idle,                    0, 1, 1, NRM, 2, 2, 1, 0);
    step("mem_end", idle,                    0, 1, 1, NRM, 0, 0, 1, 0);

    // one unrelated instruction in between: forward from WB
    step("wb_add", mk(1, 1, 2, 5, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("wb_or",  mk(1, 3, 4, 8, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("wb_sub", mk(1, 5, 5, 6, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("wb_fwd", idle,                    0, 1, 1, NRM, 1, 1, 1, 0);
    repeat (2) step("wb_drain", idle, 0, 1, 1, NRM, 0, 0, 1, 0);

    // x0 producers in MEM/WB and a load to x0 never forward or stall
    step("x0_add",  mk(1, 1, 1, 0, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("x0_ld",   mk(1, 1, 0, 0, 1, 1, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("x0_use",  mk(1, 0, 0, 7, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 0);
    step("x0_fwd",  idle,                    0, 1, 1, NRM, 0, 0, 1, 0);
    repeat (2) step("x0_drain", idle, 0, 1, 1, NRM, 0, 0, 1, 0);

    // taken branch: flushed instruction must not forward later
    step("br_add",   mk(1, 1, 2, 9, 1, 0, 0),    0, 1, 1, NRM, 0, 0, 1, 0);
    step("br_flush", mk(1, 9, 9, 11, 1, 0, 0),   1, 1, 1, FL,  0, 0, 1, 0);
    step("br_next",  mk(1, 11, 11, 12, 1, 0, 0), 0, 1, 1, NRM, 0, 0, 1, 1);
    step("br_nofwd", idle,                       0, 1, 1, NRM, 0, 0, 1, 1);
    repeat (2) step("br_drain", idle, 0, 1, 1, NRM, 0, 0, 1, 1);

    // store in MEM, dmem busy 3 cycles with a pending branch
    step("fz_sw",   mk(1, 1, 2, 0, 0, 0, 1),    0, 1, 1, NRM, 0, 0, 1, 1);
    step("fz_add",  mk(1, 1, 1, 13, 1, 0, 0),   0, 1, 1, NRM, 0, 0, 1, 1);
    repeat (3) step("fz_hold", mk(1, 13, 13, 15, 1, 0, 0), 1, 0, 1, FZ, 0, 0, 1, 1);
    step("fz_flush", mk(1, 13, 13, 15, 1, 0, 0), 1, 1, 1, FL,  0, 0, 1, 1);
    step("fz_after", mk(1, 13, 0, 16, 1, 0, 0),  0, 1, 1, NRM, 0, 0, 1, 2);
    step("fz_wbfwd", idle,                       0, 1, 1, NRM, 1, 0, 1, 2);
    step("fz_end",   idle,                       0, 1, 1, NRM, 0, 0, 1, 2);

    // asynchronous reset in the middle of a freeze
    step("rf_sw",    mk(1, 1, 2, 0, 0, 0, 1), 0, 1, 1, NRM, 0, 0, 1, 2);
    step("rf_ex",    idle,                    0, 1, 1, NRM, 0, 0, 1, 2);
    step("rf_fz",    idle,                    0, 0, 1, FZ,  0, 0, 1, 2);
    step("rf_rst",   idle,                    0, 0, 0, NRM, 0, 0, 0, 0);
    step("rf_empty", idle,                    0, 0, 1, NRM, 0, 0, 0, 0);
    step("rf_run",   idle,                    0, 1, 1, NRM, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
